// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and helpers
// for the register file write-port controller.
package regfile_pkg;

  localparam int NREGS = 16;
  localparam int WIDTH = 4;
  localparam int ADDRW = 4;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic logic [NREGS-1:0] onehot(
    input logic [ADDRW-1:0] addr
  );
    logic [NREGS-1:0] r;
    r = '0;
    r[addr] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer
// names the requester that wins a contest.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr;

  assign gnt[0] = enable & req[0]
                & (~req[1] | ~ptr);
  assign gnt[1] = enable & req[1]
                & (~req[0] | ptr);

  // Flips on every transfer, contested or not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller: shares the register file
// write port between two requesters, plus bulk clear.
module regfile_wr_arbiter #(
  parameter int NREGS = 16,
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [$clog2(NREGS)-1:0] a_addr,
  input  logic [WIDTH-1:0]         a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [$clog2(NREGS)-1:0] b_addr,
  input  logic [WIDTH-1:0]         b_data,
  output logic                     b_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [NREGS-1:0]         load,
  output logic [WIDTH-1:0]         d
);

  import regfile_pkg::*;

  state_t                     state;
  logic [$clog2(NREGS)-1:0]   cnt;
  logic [1:0]                 gnt;
  logic                       enable;

  assign enable  = (state == RUN) & ~clr_start;
  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign clr_busy = (state == CLEAR);

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({b_valid, a_valid}),
    .enable (enable),
    .accept (a_ready | b_ready),
    .gnt    (gnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      load     <= '0;
      d        <= '0;
      clr_done <= 1'b0;
    end else begin
      load     <= '0;
      clr_done <= 1'b0;
      unique case (state)
        RUN: begin
          unique case (1'b1)
            clr_start: state <= CLEAR;
            a_ready: begin
              load <= onehot(a_addr);
              d    <= a_data;
            end
            b_ready: begin
              load <= onehot(b_addr);
              d    <= b_data;
            end
            default: ;
          endcase
        end
        CLEAR: begin
          load <= onehot(cnt);
          d    <= '0;
          cnt  <= cnt + 1'b1;
          // Last index wraps cnt and ends the sweep.
          if (cnt == '1) begin
            state    <= RUN;
            clr_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: vector table, corner
// sequences and randomized model comparison.
module tb_regfile_wr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [3:0]  a_addr, b_addr;
  logic [3:0]  a_data, b_data;
  logic        a_ready, b_ready;
  logic        clr_start, clr_busy, clr_done;
  logic [15:0] load;
  logic [3:0]  d;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  regfile_wr_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .load      (load),
    .d         (d)
  );

  typedef struct {
    logic       av;
    logic [3:0] aa;
    logic [3:0] ad;
    logic       bv;
    logic [3:0] ba;
    logic [3:0] bd;
    logic       ar;
    logic       br;
    logic [15:0] ld;
    logic [3:0] dd;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic idle_in();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    clr_start = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reference model state.
  logic        m_nextb;
  int          m_left;
  logic [15:0] m_load;
  logic [3:0]  m_d;
  logic        m_done;

  initial begin
    logic [15:0] one;
    logic        ea, eb;
    one = 16'd1;

    vt[0] = '{0,0,0, 0,0,0, 0,0, 16'h0000, 4'h0};
    vt[1] = '{1,3,4'hA, 0,0,0, 1,0, 16'h0008, 4'hA};
    vt[2] = '{0,0,0, 0,0,0, 0,0, 16'h0000, 4'hA};
    vt[3] = '{0,0,0, 1,5,7, 0,1, 16'h0020, 4'h7};
    vt[4] = '{1,1,5, 1,2,6, 1,0, 16'h0002, 4'h5};
    vt[5] = '{1,1,5, 1,2,6, 0,1, 16'h0004, 4'h6};
    vt[6] = '{1,15,4'hF, 0,0,0, 1,0, 16'h8000, 4'hF};
    vt[7] = '{1,0,1, 1,0,2, 0,1, 16'h0001, 4'h2};
    vt[8] = '{1,0,1, 1,0,2, 1,0, 16'h0001, 4'h1};

    do_reset();
    #1;
    chk("rst_load", load, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_ar", a_ready, 0);
    chk("rst_br", b_ready, 0);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      a_valid = vt[i].av; a_addr = vt[i].aa;
      a_data = vt[i].ad;
      b_valid = vt[i].bv; b_addr = vt[i].ba;
      b_data = vt[i].bd;
      #1;
      chk($sformatf("vec%0d_ar", i), a_ready, vt[i].ar);
      chk($sformatf("vec%0d_br", i), b_ready, vt[i].br);
      @(posedge clock); #1;
      chk($sformatf("vec%0d_load", i), load, vt[i].ld);
      chk($sformatf("vec%0d_d", i), d, vt[i].dd);
    end

    // Contest from reset: A, B, A, B.
    do_reset();
    a_valid = 1; a_addr = 1; a_data = 5;
    b_valid = 1; b_addr = 2; b_data = 6;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_ar", k), a_ready, k % 2 == 0);
      chk($sformatf("rr%0d_br", k), b_ready, k % 2 == 1);
      @(posedge clock); #1;
      chk($sformatf("rr%0d_load", k), load,
          (k % 2 == 0) ? 16'h0002 : 16'h0004);
      @(negedge clock);
    end
    idle_in();

    // Clear launched alongside an A request.
    do_reset();
    a_valid = 1; a_addr = 4; a_data = 9;
    clr_start = 1;
    #1;
    chk("clr0_ar", a_ready, 0);
    @(posedge clock); #1;
    chk("clr0_busy", clr_busy, 1);
    chk("clr0_load", load, 0);
    @(negedge clock);
    clr_start = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("clr%0d_ar", k), a_ready, 0);
      @(posedge clock); #1;
      chk($sformatf("clr%0d_load", k), load, one << k);
      chk($sformatf("clr%0d_d", k), d, 0);
      chk($sformatf("clr%0d_busy", k), clr_busy, k < 15);
      chk($sformatf("clr%0d_done", k), clr_done, k == 15);
      @(negedge clock);
    end
    #1;
    chk("post_clr_ar", a_ready, 1);
    @(posedge clock); #1;
    chk("post_clr_load", load, 16'h0010);
    chk("post_clr_d", d, 4'h9);
    chk("post_clr_done", clr_done, 0);
    @(negedge clock);
    idle_in();

    // Reset in the middle of a clear.
    clr_start = 1;
    @(negedge clock);
    clr_start = 0;
    repeat (8) @(posedge clock);
    #1;
    chk("mid_load7", load, 16'h0080);
    reset = 1'b1;
    #1;
    chk("mid_rst_load", load, 0);
    chk("mid_rst_busy", clr_busy, 0);
    @(negedge clock);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(posedge clock); #1;
        if (clr_done !== 1'b0 || clr_busy !== 1'b0
            || load !== 16'h0) seen++;
      end
      chk("mid_no_resume", seen, 0);
    end
    @(negedge clock);
    clr_start = 1;
    @(negedge clock);
    clr_start = 0;
    @(posedge clock); #1;
    chk("restart_load", load, 16'h0001);

    // Randomized run against the model.
    do_reset();
    m_nextb = 0; m_left = 0;
    m_load = 0; m_d = 0; m_done = 0;
    for (int c = 0; c < 400; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr = 4'($urandom); a_data = 4'($urandom);
      b_addr = 4'($urandom); b_data = 4'($urandom);
      clr_start = ($urandom_range(0, 39) == 0);
      ea = (m_left == 0) && !clr_start && a_valid
           && (!b_valid || !m_nextb);
      eb = (m_left == 0) && !clr_start && b_valid
           && (!a_valid || m_nextb);
      #1;
      chk("rnd_ar", a_ready, ea);
      chk("rnd_br", b_ready, eb);
      if (m_left > 0) begin
        m_load = one << (16 - m_left);
        m_d = 0;
        m_left--;
        m_done = (m_left == 0);
      end else begin
        m_done = 0;
        m_load = 0;
        if (clr_start) m_left = 16;
        else if (ea) begin
          m_load = one << a_addr; m_d = a_data;
        end else if (eb) begin
          m_load = one << b_addr; m_d = b_data;
        end
        if (ea || eb) m_nextb = ~m_nextb;
      end
      @(posedge clock); #1;
      chk("rnd_load", load, m_load);
      chk("rnd_d", d, m_d);
      chk("rnd_busy", clr_busy, m_left > 0);
      chk("rnd_done", clr_done, m_done);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
